dut_sampler: RTL and testbench

Stimulus/capture stage wrapped around the combinational dut.
- Accepts a 32-bit test vector over a valid/ready handshake.
- Drives dut_input with it, then steps dut_signal_select through bits 0..31, waiting a settle interval before sampling dut_output each time.
- Assembles the 32 sampled bits into one result word, returned over a second valid/ready handshake.
- Lets host logic read the full dut response through the dut's single-bit output.

---
 rtl/dut_sampler_pkg.sv | 15 +
 rtl/dut_sampler_if.sv | 28 ++
 rtl/dut_sampler_settle_timer.sv | 31 +++
 rtl/dut_sampler.sv | 93 +++++++++
 tb/tb_dut_sampler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dut_sampler_pkg.sv
// rtl/dut_sampler_pkg.sv - shared types and constants for the dut stimulus/capture sampler
package dut_sampler_pkg;

    localparam int DATA_WIDTH            = 32;
    localparam int SEL_BITS              = 5;
    localparam int DEFAULT_SETTLE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/dut_sampler_if.sv
// rtl/dut_sampler_if.sv - command, result and dut-side signal bundle for the sampler
interface dut_sampler_if;
    import dut_sampler_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  result_valid;
    logic                  result_ready;
    logic [DATA_WIDTH-1:0] result_data;
    logic                  busy;
    logic [DATA_WIDTH-1:0] dut_input;
    logic [DATA_WIDTH-1:0] dut_signal_select;
    logic                  dut_output;

    // host/environment side: issues vectors, consumes results, models the dut
    modport master (
        output cmd_valid, cmd_data, result_ready, dut_output,
        input  cmd_ready, result_valid, result_data, busy, dut_input, dut_signal_select
    );

    // sampler side
    modport slave (
        input  cmd_valid, cmd_data, result_ready, dut_output,
        output cmd_ready, result_valid, result_data, busy, dut_input, dut_signal_select
    );

endinterface

// File: rtl/dut_sampler_settle_timer.sv
// rtl/dut_sampler_settle_timer.sv - loadable down-counter flagging the end of a settle interval
module dut_sampler_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic done
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    // reload at the start of each interval, then count down while the owner waits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // done is asserted on the last waiting cycle so the owner leaves on the following edge
    assign done = run && (cnt == '0);

endmodule

// File: rtl/dut_sampler.sv
// rtl/dut_sampler.sv - drives a vector into the dut and reads its response one selected bit at a time
module dut_sampler
    import dut_sampler_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic          clk,
    input  logic          rst_n,
    dut_sampler_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SETTLE  = SETTLE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_DONE    = DONE;

    // with no settle interval a new select value is sampled on the very next cycle
    localparam logic [1:0] ST_WAIT = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;

    localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(DATA_WIDTH - 1);

    logic [1:0]            state;
    logic [SEL_BITS-1:0]   bit_idx;
    logic [DATA_WIDTH-1:0] dut_input_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  accept;
    logic                  last_bit;
    logic                  timer_load;
    logic                  timer_done;

    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign last_bit   = (bit_idx == LAST_IDX);
    assign timer_load = accept || ((state == ST_CAPTURE) && !last_bit);

    dut_sampler_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .run   (state == ST_SETTLE),
        .done  (timer_done)
    );

    // sequencing FSM: accept vector, settle/capture each bit, hold result until consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            dut_input_q <= '0;
            result_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dut_input_q <= bus.cmd_data;
                        bit_idx     <= '0;
                        state       <= ST_WAIT;
                    end
                end
                ST_SETTLE: begin
                    if (timer_done) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    result_q[bit_idx] <= bus.dut_output;
                    if (last_bit) begin
                        state <= ST_DONE;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (bus.result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // cmd_ready is gated by reset so nothing is accepted while the block is held
    assign bus.cmd_ready         = rst_n && (state == ST_IDLE);
    assign bus.result_valid      = (state == ST_DONE);
    assign bus.result_data       = result_q;
    assign bus.busy              = (state != ST_IDLE);
    assign bus.dut_input         = dut_input_q;
    assign bus.dut_signal_select = {{(DATA_WIDTH - SEL_BITS){1'b0}}, bit_idx};

endmodule

// File: tb/tb_dut_sampler.sv
// tb/tb_dut_sampler.sv - self-checking bench for dut_sampler with settle intervals of 4 and 0
module tb_dut_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  cmd_valid, result_ready, cmd_ready, result_valid, busy;
    logic [31:0] cmd_data [2];
    logic [31:0] result_data [2];
    logic [31:0] dut_input [2];
    logic [31:0] dut_sel [2];
    logic [31:0] resp0, resp1;

    int n_cmp  = 0;
    int n_fail = 0;

    dut_sampler_if if0();
    dut_sampler_if if1();

    dut_sampler #(.SETTLE_CYCLES(4)) u_s4 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    dut_sampler #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // behavioural dut: sum of 16-bit halves, except a trojan vector that is passed through unchanged
    function automatic logic [31:0] ref_resp(input logic [31:0] v);
        if (v == 32'hDEADBEEF) return v;
        return 32'(v[31:16]) + 32'(v[15:0]);
    endfunction

    function automatic int settle_of(input int inst);
        return (inst == 0) ? 4 : 0;
    endfunction

    assign resp0 = ref_resp(if0.dut_input);
    assign resp1 = ref_resp(if1.dut_input);
    assign if0.dut_output = resp0[if0.dut_signal_select[4:0]];
    assign if1.dut_output = resp1[if1.dut_signal_select[4:0]];

    assign if0.cmd_valid    = cmd_valid[0];
    assign if1.cmd_valid    = cmd_valid[1];
    assign if0.cmd_data     = cmd_data[0];
    assign if1.cmd_data     = cmd_data[1];
    assign if0.result_ready = result_ready[0];
    assign if1.result_ready = result_ready[1];
    assign cmd_ready        = {if1.cmd_ready, if0.cmd_ready};
    assign result_valid     = {if1.result_valid, if0.result_valid};
    assign busy             = {if1.busy, if0.busy};
    assign result_data[0]   = if0.result_data;
    assign result_data[1]   = if1.result_data;
    assign dut_input[0]     = if0.dut_input;
    assign dut_input[1]     = if1.dut_input;
    assign dut_sel[0]       = if0.dut_signal_select;
    assign dut_sel[1]       = if1.dut_signal_select;

    // presents one vector, then follows the run edge by edge until result_valid (bounded)
    task automatic run_vector(input int inst, input logic [31:0] data, output logic [31:0] res,
                              output int lat, output int sel_err, output int din_err);
        int   s;
        int   exp_sel;
        logic rdy;
        bit   acc;
        s = settle_of(inst);
        res = '0; lat = -1; sel_err = 0; din_err = 0; acc = 1'b0;
        cmd_valid[inst] = 1'b1;
        cmd_data[inst]  = data;
        for (int w = 0; w < 20 && !acc; w++) begin
            rdy = cmd_ready[inst];
            @(posedge clk); #1;
            acc = rdy;
        end
        cmd_valid[inst] = 1'b0;
        cmd_data[inst]  = $urandom;
        if (!acc) return;
        for (int j = 0; j <= 400; j++) begin
            if (result_valid[inst] === 1'b1) begin
                lat = j;
                res = result_data[inst];
                break;
            end
            exp_sel = j / (s + 1);
            if (exp_sel > 31) exp_sel = 31;
            if (dut_sel[inst] !== 32'(exp_sel)) sel_err++;
            if (dut_input[inst] !== data) din_err++;
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_result(input int inst);
        result_ready[inst] = 1'b1;
        @(posedge clk); #1;
        result_ready[inst] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (result_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid[%0d]: got %b want 0", i, result_valid[i]); end
            n_cmp++; if (busy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
            n_cmp++; if (cmd_ready[i] !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready_low[%0d]: got %b want 0", i, cmd_ready[i]); end
            n_cmp++; if (dut_input[i] !== 32'h0) begin n_fail++; $display("FAIL reset_dut_input[%0d]: got %h want 0", i, dut_input[i]); end
            n_cmp++; if (dut_sel[i] !== 32'h0) begin n_fail++; $display("FAIL reset_select[%0d]: got %h want 0", i, dut_sel[i]); end
            n_cmp++; if (result_data[i] !== 32'h0) begin n_fail++; $display("FAIL reset_result_data[%0d]: got %h want 0", i, result_data[i]); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 2'b11) begin n_fail++; $display("FAIL reset_cmd_ready_idle: got %b want 11", cmd_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int lat, se, de;
        run_vector(0, 32'h00030005, res, lat, se, de);
        n_cmp++; if (res !== 32'h00000008) begin n_fail++; $display("FAIL basic_result: got %h want 00000008", res); end
        n_cmp++; if (lat != 160) begin n_fail++; $display("FAIL basic_latency: got %0d want 160", lat); end
        n_cmp++; if (se != 0) begin n_fail++; $display("FAIL basic_select_sequence: got %0d bad cycles want 0", se); end
        n_cmp++; if (de != 0) begin n_fail++; $display("FAIL basic_dut_input_hold: got %0d bad cycles want 0", de); end
        finish_result(0);
        n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy[0]); end
        n_cmp++; if (result_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b want 0", result_valid[0]); end
        n_cmp++; if (dut_input[0] !== 32'h00030005) begin n_fail++; $display("FAIL basic_idle_dut_input: got %h want 00030005", dut_input[0]); end
    endtask

    task automatic test_trojan();
        logic [31:0] res;
        int lat, se, de;
        run_vector(0, 32'hDEADBEEF, res, lat, se, de);
        n_cmp++; if (res !== 32'hDEADBEEF) begin n_fail++; $display("FAIL trojan_result: got %h want deadbeef", res); end
        n_cmp++; if (lat != 160) begin n_fail++; $display("FAIL trojan_latency: got %0d want 160", lat); end
        finish_result(0);
    endtask

    task automatic test_zero_settle();
        logic [31:0] res;
        int lat, se, de;
        run_vector(1, 32'hFFFF0001, res, lat, se, de);
        n_cmp++; if (res !== 32'h00010000) begin n_fail++; $display("FAIL zero_settle_result: got %h want 00010000", res); end
        n_cmp++; if (lat != 32) begin n_fail++; $display("FAIL zero_settle_latency: got %0d want 32", lat); end
        n_cmp++; if (se != 0) begin n_fail++; $display("FAIL zero_settle_select_sequence: got %0d bad cycles want 0", se); end
        finish_result(1);
    endtask

    task automatic test_backpressure();
        logic [31:0] v, v2, res;
        int lat, se, de, bad, j;
        v  = $urandom;
        v2 = $urandom;
        run_vector(0, v, res, lat, se, de);
        n_cmp++; if (res !== ref_resp(v)) begin n_fail++; $display("FAIL bp_first_result: got %h want %h", res, ref_resp(v)); end
        cmd_valid[0] = 1'b1;
        cmd_data[0]  = v2;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (result_valid[0] !== 1'b1 || result_data[0] !== ref_resp(v) || cmd_ready[0] !== 1'b0 ||
                dut_input[0] !== v || busy[0] !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d bad cycles want 0", bad); end
        result_ready[0] = 1'b1;
        @(posedge clk); #1;
        result_ready[0] = 1'b0;
        n_cmp++; if (busy[0] !== 1'b0 || result_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release_idle: got busy=%b valid=%b want 0/0", busy[0], result_valid[0]); end
        n_cmp++; if (dut_input[0] !== v) begin n_fail++; $display("FAIL bp_no_same_cycle_accept: got %h want %h", dut_input[0], v); end
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        n_cmp++; if (busy[0] !== 1'b1 || dut_input[0] !== v2) begin n_fail++; $display("FAIL bp_accept_next: got busy=%b din=%h want 1/%h", busy[0], dut_input[0], v2); end
        lat = -1;
        for (j = 0; j <= 400; j++) begin
            if (result_valid[0] === 1'b1) begin lat = j; break; end
            @(posedge clk); #1;
        end
        n_cmp++; if (lat != 160) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 160", lat); end
        n_cmp++; if (result_data[0] !== ref_resp(v2)) begin n_fail++; $display("FAIL bp_second_result: got %h want %h", result_data[0], ref_resp(v2)); end
        finish_result(0);
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v, res;
        int lat, se, de, stale;
        bit found;
        v = $urandom;
        cmd_valid[0] = 1'b1;
        cmd_data[0]  = v;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 200 && !found; j++) begin
            if (dut_sel[0] === 32'd12) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL midrun_reach_bit12: got %b want 1", found); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (result_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL midrun_abort: got valid=%b busy=%b want 0/0", result_valid[0], busy[0]); end
        n_cmp++; if (dut_sel[0] !== 32'h0 || dut_input[0] !== 32'h0) begin n_fail++; $display("FAIL midrun_clear: got sel=%h din=%h want 0/0", dut_sel[0], dut_input[0]); end
        n_cmp++; if (cmd_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midrun_cmd_ready: got %b want 0", cmd_ready[0]); end
        rst_n = 1'b1;
        stale = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (result_valid[0] !== 1'b0 || busy[0] !== 1'b0) stale++;
        end
        n_cmp++; if (stale != 0) begin n_fail++; $display("FAIL midrun_stale_completion: got %0d bad cycles want 0", stale); end
        v = $urandom;
        run_vector(0, v, res, lat, se, de);
        n_cmp++; if (res !== ref_resp(v)) begin n_fail++; $display("FAIL midrun_rerun_result: got %h want %h", res, ref_resp(v)); end
        n_cmp++; if (lat != 160) begin n_fail++; $display("FAIL midrun_rerun_latency: got %0d want 160", lat); end
        finish_result(0);
    endtask

    task automatic test_random();
        logic [31:0] v, res;
        int lat, se, de, inst;
        bit rr;
        for (int k = 0; k < 8; k++) begin
            inst = k % 2;
            v    = (k == 5) ? 32'hDEADBEEF : $urandom;
            rr   = (k % 3 == 0);
            result_ready[inst] = rr;
            run_vector(inst, v, res, lat, se, de);
            n_cmp++; if (res !== ref_resp(v)) begin n_fail++; $display("FAIL random_result[%0d]: got %h want %h", k, res, ref_resp(v)); end
            n_cmp++; if (lat != 32 * (settle_of(inst) + 1)) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d want %0d", k, lat, 32 * (settle_of(inst) + 1)); end
            n_cmp++; if (se != 0 || de != 0) begin n_fail++; $display("FAIL random_monitor[%0d]: got sel_err=%0d din_err=%0d want 0/0", k, se, de); end
            if (rr) begin
                @(posedge clk); #1;
                result_ready[inst] = 1'b0;
            end else begin
                finish_result(inst);
            end
            n_cmp++; if (busy[inst] !== 1'b0) begin n_fail++; $display("FAIL random_back_to_idle[%0d]: got %b want 0", k, busy[inst]); end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 2'b00;
        result_ready = 2'b00;
        cmd_data[0]  = '0;
        cmd_data[1]  = '0;
        test_reset();
        test_basic();
        test_trojan();
        test_zero_settle();
        test_backpressure();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
